// File: rtl/tlk2711_pkg.sv
// Shared types and constants for the TLK2711 DMA write path.
package tlk2711_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_AW,
    ST_W,
    ST_B,
    ST_DONE
  } wr_state_t;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B    = 3'd3;

  // AXI bursts may not cross this address boundary.
  localparam int BOUNDARY_4K    = 4096;
  // log2 of bytes per 64-bit beat.
  localparam int BEAT_SHIFT     = 3;
  // Beats that fit in one 4 KB page, and the address bits indexing a beat within it.
  localparam int PAGE_BEATS     = BOUNDARY_4K >> BEAT_SHIFT;
  localparam int PAGE_IDX_WIDTH = $clog2(PAGE_BEATS);

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/tlk2711_burst_calc.sv
// Burst length for the next AXI write: min(remaining, MAX_BURST, beats left in the 4 KB page).
// Result is registered; it is valid the cycle after en is asserted.
module tlk2711_burst_calc
  import tlk2711_pkg::*;
#(
  parameter int REM_WIDTH  = 13,
  parameter int MAX_BURST  = 16,
  parameter int BLEN_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [PAGE_IDX_WIDTH-1:0] page_idx,
  input  logic [REM_WIDTH-1:0]      remaining,
  output logic [BLEN_WIDTH-1:0]     blen
);

  int unsigned to_boundary;
  int unsigned limit;

  // Three-way minimum; page_idx is the beat offset inside the current 4 KB page.
  always_comb begin
    to_boundary = 32'(PAGE_BEATS) - 32'(page_idx);
    limit       = min_u(min_u(32'(remaining), 32'(MAX_BURST)), to_boundary);
  end

  // Capture the burst length while the engine sits in its calculation state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blen <= '0;
    end else if (en) begin
      blen <= BLEN_WIDTH'(limit);
    end
  end

endmodule

// File: rtl/tlk2711_dma_wr_engine.sv
// Turns {address, byte length} write commands plus a 64-bit FWFT data stream
// into AXI4 INCR write bursts, one burst outstanding at a time.
module tlk2711_dma_wr_engine
  import tlk2711_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DLEN_WIDTH  = 16,
  parameter int DATA_WIDTH  = 64,
  parameter int WBYTE_WIDTH = 8,
  parameter int MAX_BURST   = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_soft_rst,
  input  logic                             i_wr_cmd_req,
  output logic                             o_wr_cmd_ack,
  input  logic [ADDR_WIDTH+DLEN_WIDTH-1:0] i_wr_cmd_data,
  input  logic                             i_dma_wr_valid,
  input  logic [WBYTE_WIDTH-1:0]           i_dma_wr_keep,
  input  logic [DATA_WIDTH-1:0]            i_dma_wr_data,
  output logic                             o_dma_wr_ready,
  output logic                             o_wr_finish,
  output logic                             o_wr_err,
  output logic                             o_busy,
  output logic [ADDR_WIDTH-1:0]            m_axi_awaddr,
  output logic [7:0]                       m_axi_awlen,
  output logic [2:0]                       m_axi_awsize,
  output logic [1:0]                       m_axi_awburst,
  output logic                             m_axi_awvalid,
  input  logic                             m_axi_awready,
  output logic [DATA_WIDTH-1:0]            m_axi_wdata,
  output logic [WBYTE_WIDTH-1:0]           m_axi_wstrb,
  output logic                             m_axi_wlast,
  output logic                             m_axi_wvalid,
  input  logic                             m_axi_wready,
  input  logic [1:0]                       m_axi_bresp,
  input  logic                             m_axi_bvalid,
  output logic                             m_axi_bready
);

  localparam int REM_WIDTH  = DLEN_WIDTH - BEAT_SHIFT;
  localparam int BLEN_WIDTH = $clog2(MAX_BURST + 1);

  wr_state_t               state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [REM_WIDTH-1:0]    remaining_reg;
  logic [BLEN_WIDTH-1:0]   beat_cnt_reg;
  logic [BLEN_WIDTH-1:0]   blen;
  logic                    ack_reg;
  logic                    finish_reg;
  logic                    err_reg;

  logic                    run_n;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [REM_WIDTH-1:0]    cmd_beats;
  logic                    unused_cmd_bits;
  logic                    in_aw, in_w, in_b;
  logic                    w_fire, b_fire, last_beat, final_burst;

  // Soft reset has exactly the same effect as the hard reset.
  assign run_n = rst_n & ~i_soft_rst;

  // Low length bits are already rounded up by the RX stage; low address bits are forced to 0.
  assign cmd_addr        = i_wr_cmd_data[ADDR_WIDTH+DLEN_WIDTH-1 -: ADDR_WIDTH];
  assign cmd_beats       = i_wr_cmd_data[DLEN_WIDTH-1:BEAT_SHIFT];
  assign unused_cmd_bits = ^{i_wr_cmd_data[BEAT_SHIFT-1:0], cmd_addr[BEAT_SHIFT-1:0]};

  assign in_aw = (state_reg == ST_AW);
  assign in_w  = (state_reg == ST_W);
  assign in_b  = (state_reg == ST_B);

  assign w_fire      = in_w & i_dma_wr_valid & m_axi_wready;
  assign b_fire      = in_b & m_axi_bvalid;
  assign last_beat   = (beat_cnt_reg == (blen - BLEN_WIDTH'(1)));
  assign final_burst = (remaining_reg == REM_WIDTH'(blen));

  tlk2711_burst_calc #(
    .REM_WIDTH  (REM_WIDTH),
    .MAX_BURST  (MAX_BURST),
    .BLEN_WIDTH (BLEN_WIDTH)
  ) u_burst_calc (
    .clk       (clk),
    .rst_n     (run_n),
    .en        (state_reg == ST_CALC),
    .page_idx  (addr_reg[PAGE_IDX_WIDTH+BEAT_SHIFT-1:BEAT_SHIFT]),
    .remaining (remaining_reg),
    .blen      (blen)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!run_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: command -> (calc -> AW -> W -> B)* -> done.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (i_wr_cmd_req) state_next = (cmd_beats == '0) ? ST_DONE : ST_CALC;
      ST_CALC: state_next = ST_AW;
      ST_AW:   if (m_axi_awready) state_next = ST_W;
      ST_W:    if (w_fire && last_beat) state_next = ST_B;
      ST_B:    if (m_axi_bvalid) state_next = final_burst ? ST_DONE : ST_CALC;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Command latch, burst bookkeeping, and the registered ack/finish/error flags.
  always_ff @(posedge clk) begin
    if (!run_n) begin
      addr_reg      <= '0;
      remaining_reg <= '0;
      beat_cnt_reg  <= '0;
      ack_reg       <= 1'b0;
      finish_reg    <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      ack_reg    <= 1'b0;
      finish_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (i_wr_cmd_req) begin
            ack_reg       <= 1'b1;
            addr_reg      <= {cmd_addr[ADDR_WIDTH-1:BEAT_SHIFT], {BEAT_SHIFT{1'b0}}};
            remaining_reg <= cmd_beats;
          end
        end
        ST_AW: beat_cnt_reg <= '0;
        ST_W: begin
          if (w_fire) beat_cnt_reg <= beat_cnt_reg + BLEN_WIDTH'(1);
        end
        ST_B: begin
          if (b_fire) begin
            if (m_axi_bresp != AXI_RESP_OKAY) err_reg <= 1'b1;
            addr_reg      <= addr_reg + (ADDR_WIDTH'(blen) << BEAT_SHIFT);
            remaining_reg <= remaining_reg - REM_WIDTH'(blen);
          end
        end
        ST_DONE: finish_reg <= 1'b1;
        default: ;
      endcase
    end
  end

  assign o_wr_cmd_ack = ack_reg;
  assign o_wr_finish  = finish_reg;
  assign o_wr_err     = err_reg;
  assign o_busy       = (state_reg != ST_IDLE);

  // AW fields come straight from registers, so they hold steady while awready is low.
  assign m_axi_awvalid = in_aw;
  assign m_axi_awaddr  = in_aw ? addr_reg : '0;
  assign m_axi_awlen   = in_aw ? 8'(blen - BLEN_WIDTH'(1)) : 8'd0;
  assign m_axi_awsize  = in_aw ? AXI_SIZE_8B : 3'd0;
  assign m_axi_awburst = in_aw ? AXI_BURST_INCR : 2'b00;

  // Upstream ready follows wready only, never the upstream valid.
  assign o_dma_wr_ready = in_w & m_axi_wready;
  assign m_axi_wvalid   = in_w & i_dma_wr_valid;
  assign m_axi_wdata    = in_w ? i_dma_wr_data : '0;
  assign m_axi_wstrb    = in_w ? i_dma_wr_keep : '0;
  assign m_axi_wlast    = in_w & last_beat;

  assign m_axi_bready = in_b;

endmodule
